// File: rtl/simon_128_128.sv
// simon_128_128: iterative SIMON 128/128 core, one round per clock, with on-chip key expansion.
// Define SIMON_DECRYPT_EN to add the decrypt direction selected by enc_dec.
module simon_128_128 #(
   parameter int N = 64,
   parameter int M = 2,
   parameter int T = 68,
   parameter int Co = 7
) (
   input  logic                clk,
   input  logic                nR,
   input  logic                newData,
   input  logic                newKey,
   input  logic                enc_dec,
   input  logic                readData,
   input  logic [2*N-1:0]      plain,
   input  logic [M-1:0][N-1:0] key,
   output logic                ldData,
   output logic                ldKey,
   output logic                doneData,
   output logic                doneKey,
   output logic [2*N-1:0]      cipher
);
   // z2 sequence, bit i holds z2[i]
   localparam logic [61:0] Z2 = 62'h3369f885192c0ef5;
   localparam logic [Co-1:0] LAST = Co'(T - 1);
   localparam logic [Co-1:0] KEND = Co'(T - 2);

   typedef enum logic [1:0] {KIDLE, KEXP, KDONE} kstate_t;
   typedef enum logic [1:0] {DIDLE, DRUN, DOUT} dstate_t;

   kstate_t kstate, knext;
   dstate_t dstate, dnext;
   logic [N-1:0] rk [T];
   logic [Co-1:0] ki, rnd;
   logic [5:0] zi;
   logic [N-1:0] x, y, kn, kb, fx, rkey;
   logic [2*N-1:0] res, load_xy;
   logic key_load, data_load, kwrite;

   function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int s);
      return (v << s) | (v >> (N - s));
   endfunction

   assign zi = 6'(ki >= Co'(62) ? ki - Co'(62) : ki);
   assign kb = rk[ki + Co'(1)];
   assign kn = ~rk[ki] ^ rol(kb, N - 3) ^ rol(kb, N - 4) ^ N'(3) ^ N'(Z2[zi]);
   assign fx = (rol(x, 1) & rol(x, 8)) ^ rol(x, 2);

`ifdef SIMON_DECRYPT_EN
   logic dec;
   // decryption runs the same round on the swapped block with keys in reverse
   assign rkey = rk[dec ? LAST - rnd : rnd];
   assign res = dec ? {y, x} : {x, y};
   assign load_xy = enc_dec ? plain : {plain[N-1:0], plain[2*N-1:N]};
   always_ff @(posedge clk or negedge nR)
      if (!nR) dec <= 1'b0;
      else if (data_load) dec <= ~enc_dec;
`else
   logic unused_enc_dec;
   assign unused_enc_dec = enc_dec;
   assign rkey = rk[rnd];
   assign res = {x, y};
   assign load_xy = plain;
`endif

   always_ff @(posedge clk or negedge nR)
      if (!nR) begin
         kstate <= KIDLE;
         dstate <= DIDLE;
      end else begin
         kstate <= knext;
         dstate <= dnext;
      end

   always_comb begin
      knext = key_load ? KEXP : (kstate == KEXP && ki == KEND) ? KDONE : kstate;
      dnext = data_load ? DRUN :
              (dstate == DRUN && rnd == LAST) ? DOUT :
              (dstate == DOUT && !doneData) ? DIDLE : dstate;
   end

   always_comb begin
      doneKey = kstate == KDONE;
      kwrite = kstate == KEXP && ki != KEND;
      key_load = newKey && !ldKey && dstate == DIDLE;
      data_load = newData && !ldData && doneKey && dstate == DIDLE && !key_load;
   end

   always_ff @(posedge clk)
      if (key_load) begin
         rk[0] <= key[0];
         rk[1] <= key[1];
      end else if (kwrite) rk[ki + Co'(2)] <= kn;

   always_ff @(posedge clk or negedge nR)
      if (!nR) begin
         ldKey <= 1'b0;
         ldData <= 1'b0;
         doneData <= 1'b0;
         cipher <= '0;
         ki <= '0;
         rnd <= '0;
         x <= '0;
         y <= '0;
      end else begin
         ldKey <= key_load || (ldKey && newKey);
         ldData <= data_load || (ldData && newData);
         if (key_load) ki <= '0;
         else if (kwrite) ki <= ki + 1'b1;
         if (data_load) begin
            rnd <= '0;
            {x, y} <= load_xy;
         end else if (dstate == DRUN) begin
            rnd <= rnd + 1'b1;
            x <= y ^ fx ^ rkey;
            y <= x;
         end
         // a finished block waits in DOUT until the previous result is read
         if (dstate == DOUT && !doneData) begin
            cipher <= res;
            doneData <= 1'b1;
         end else if (readData) doneData <= 1'b0;
      end
endmodule

// File: tb/tb_simon_128_128.sv
// tb_simon_128_128: scoreboard bench for simon_128_128 against a software SIMON model.
module tb_simon_128_128;
   logic clk = 1'b0;
   logic nR, newData, newKey, enc_dec, readData, ldData, ldKey, doneData, doneKey;
   logic [127:0] plain, cipher;
   logic [1:0][63:0] key;
   int n_cmp = 0, n_err = 0;
   logic [127:0] exp_q [$];
   logic [127:0] cur_exp = '0;
   logic rd_en = 1'b1;
   int rd_dly = 2;
   logic done_q = 1'b0;

   localparam logic [61:0] Z2S = 62'b10101111011100000011010010011000101000010001111110010110110011;
   localparam logic [127:0] K0 = 128'h0f0e0d0c0b0a0908_0706050403020100;
   localparam logic [127:0] P0 = 128'h63736564207372656c6c657661727420;
   localparam logic [127:0] C0 = 128'h49681b1e1e54fe3f65aa832af84e0bbc;

   always #5 clk = ~clk;

   simon_128_128 dut (
      .clk(clk), .nR(nR), .newData(newData), .newKey(newKey), .enc_dec(enc_dec),
      .readData(readData), .plain(plain), .key(key), .ldData(ldData), .ldKey(ldKey),
      .doneData(doneData), .doneKey(doneKey), .cipher(cipher)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] f64(input logic [63:0] v);
      return ({v[62:0], v[63]} & {v[55:0], v[63:56]}) ^ {v[61:0], v[63:62]};
   endfunction

   function automatic logic [127:0] model(input logic [127:0] k, input logic [127:0] p, input logic enc);
      logic [63:0] ks [68];
      logic [63:0] a, b, t;
      ks[0] = k[63:0];
      ks[1] = k[127:64];
      for (int i = 0; i < 66; i++) begin
         t = {ks[i+1][2:0], ks[i+1][63:3]};
         ks[i+2] = 64'hffff_ffff_ffff_fffc ^ {63'd0, Z2S[61 - (i % 62)]} ^ ks[i] ^ t ^ {t[0], t[63:1]};
      end
      a = p[127:64];
      b = p[63:0];
      if (enc)
         for (int i = 0; i < 68; i++) begin
            t = a;
            a = b ^ f64(a) ^ ks[i];
            b = t;
         end
      else
         for (int i = 67; i >= 0; i--) begin
            t = b;
            b = a ^ f64(b) ^ ks[i];
            a = t;
         end
      return {a, b};
   endfunction

   always @(negedge clk) begin
      if (doneData && !done_q) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected result %h with nothing queued", cipher);
         end else begin
            cur_exp = exp_q.pop_front();
            check("cipher", cipher, cur_exp);
         end
      end
      done_q <= doneData;
   end

   initial begin
      readData = 1'b0;
      forever begin
         @(negedge clk);
         if (rd_en && doneData) begin
            repeat (rd_dly - 1) @(negedge clk);
            check("hold", cipher, cur_exp);
            readData = 1'b1;
            @(negedge clk);
            readData = 1'b0;
         end
      end
   end

   task automatic send(input logic [127:0] p, input logic e);
      int n = 0;
`ifdef SIMON_DECRYPT_EN
      exp_q.push_back(model(key, p, e));
`else
      exp_q.push_back(model(key, p, 1'b1));
`endif
      plain = p;
      enc_dec = e;
      newData = 1'b1;
      @(negedge clk);
      while (!ldData && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!ldData) check("ld_timeout", 128'(ldData), 128'(1));
      newData = 1'b0;
      @(negedge clk);
   endtask

   task automatic load_key(input logic [127:0] k);
      int n = 0;
      key = k;
      newKey = 1'b1;
      @(negedge clk);
      newKey = 1'b0;
      while (!doneKey && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("key_ready", 128'(doneKey), 128'(1));
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("drain", 128'(exp_q.size()), 128'(0));
      repeat (rd_dly + 3) @(negedge clk);
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [127:0] p;
      nR = 1'b0;
      newData = 1'b0;
      newKey = 1'b0;
      enc_dec = 1'b1;
      plain = '0;
      key = '0;
      repeat (2) @(negedge clk);
      check("rst_flags", 128'({ldData, ldKey, doneData, doneKey}), 128'(0));
      check("rst_cipher", cipher, '0);
      nR = 1'b1;
      @(negedge clk);
      key = K0;
      newKey = 1'b1;
      @(negedge clk);
      check("ldKey", 128'(ldKey), 128'(1));
      check("doneKey_low", 128'(doneKey), 128'(0));
      newKey = 1'b0;
      n = 0;
      while (!doneKey && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("key_lat", 128'(n), 128'(67));
      check("ldKey_drop", 128'(ldKey), 128'(0));
      check("k0", 128'(dut.rk[0]), 128'(K0[63:0]));
      check("k1", 128'(dut.rk[1]), 128'(K0[127:64]));

      exp_q.push_back(C0);
      plain = P0;
      enc_dec = 1'b1;
      newData = 1'b1;
      @(negedge clk);
      check("ldData", 128'(ldData), 128'(1));
      newData = 1'b0;
      n = 0;
      while (!doneData && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("enc_lat", 128'(n), 128'(69));
      repeat (3) @(negedge clk);
      check("done_clr", 128'(doneData), 128'(0));

`ifdef SIMON_DECRYPT_EN
      exp_q.push_back(P0);
      plain = C0;
      enc_dec = 1'b0;
      newData = 1'b1;
      @(negedge clk);
      newData = 1'b0;
      drain();
`endif

      rd_dly = 2;
      for (int i = 0; i < 5; i++) send(rnd128(), 1'($urandom_range(0, 1)));
      drain();

      rd_dly = 100;
      for (int i = 0; i < 3; i++) send(rnd128(), 1'($urandom_range(0, 1)));
      drain();
      rd_dly = 2;

      key = rnd128();
      newKey = 1'b1;
      @(negedge clk);
      newKey = 1'b0;
      p = rnd128();
      exp_q.push_back(model(key, p, 1'b1));
      plain = p;
      enc_dec = 1'b1;
      newData = 1'b1;
      repeat (10) @(negedge clk);
      check("pend_ld", 128'(ldData), 128'(0));
      n = 10;
      while (!ldData && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("pend_lat", 128'(n), 128'(68));
      check("pend_doneKey", 128'(doneKey), 128'(1));
      newData = 1'b0;
      drain();

      send(rnd128(), 1'b1);
      repeat (30) @(negedge clk);
      #2 nR = 1'b0;
      #1;
      check("arst_flags", 128'({ldData, ldKey, doneData, doneKey}), 128'(0));
      check("arst_cipher", cipher, '0);
      exp_q.delete();
      @(negedge clk);
      nR = 1'b1;
      @(negedge clk);
      load_key(rnd128());
      send(rnd128(), 1'b1);
      send(rnd128(), 1'b0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
